// File: rtl/hero_pkg.sv
// Shared definitions for the hero move arbiter: direction codes, FSM state
// encoding, collision-block bit indices and the button priority picker.
package hero_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_LEFT  = 3'd2,
        DIR_RIGHT = 3'd3,
        DIR_DOWN  = 3'd4
    } dir_e;

    // Encoding 2'd3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ATK  = 2'd2
    } state_e;

    localparam logic [1:0] BLK_UP    = 2'd0;
    localparam logic [1:0] BLK_LEFT  = 2'd1;
    localparam logic [1:0] BLK_RIGHT = 2'd2;
    localparam logic [1:0] BLK_DOWN  = 2'd3;

    typedef struct packed {
        logic       is_dir;
        logic       is_center;
        dir_e       dir;
        logic [1:0] blk_idx;
    } pick_t;

    // Only the highest-priority pressed button survives; lower ones are discarded.
    function automatic pick_t pick_button(
        input logic up,
        input logic left,
        input logic right,
        input logic down,
        input logic center
    );
        pick_t p;
        p.is_dir    = 1'b0;
        p.is_center = 1'b0;
        p.dir       = DIR_NONE;
        p.blk_idx   = BLK_UP;
        if (up) begin
            p.is_dir  = 1'b1;
            p.dir     = DIR_UP;
            p.blk_idx = BLK_UP;
        end else if (left) begin
            p.is_dir  = 1'b1;
            p.dir     = DIR_LEFT;
            p.blk_idx = BLK_LEFT;
        end else if (right) begin
            p.is_dir  = 1'b1;
            p.dir     = DIR_RIGHT;
            p.blk_idx = BLK_RIGHT;
        end else if (down) begin
            p.is_dir  = 1'b1;
            p.dir     = DIR_DOWN;
            p.blk_idx = BLK_DOWN;
        end else begin
            p.is_center = center;
        end
        return p;
    endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Free-running movement-step prescaler; tick is high for the one cycle in
// which the count sits at DIV-1.
module step_tick_gen #(
    parameter int unsigned DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned       CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DIV - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_r;
    logic             tick_r;

    // Count and a registered tick that is pre-decoded one count early so it
    // lines up exactly with count == DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
            tick_r  <= 1'b0;
        end else begin
            if (count_r == CNT_LAST) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + CNT_ONE;
            end
            tick_r <= (count_r == CNT_PRE);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/hero_move_arbiter.sv
// Hero move/attack arbiter: on each movement step picks the highest-priority
// button and issues a handshaked move command or a cooldown-limited attack.
module hero_move_arbiter
    import hero_pkg::*;
#(
    parameter int unsigned STEP_DIV        = 100000,
    parameter int unsigned ATTACK_COOLDOWN = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       up,
    input  logic       left,
    input  logic       right,
    input  logic       down,
    input  logic       center,
    input  logic [3:0] blocked,
    input  logic       move_ack,
    output logic       move_req,
    output logic [2:0] move_dir,
    output logic       attack,
    output logic       busy
);

    localparam int unsigned      CD_W    = $clog2(ATTACK_COOLDOWN + 1);
    localparam logic [CD_W-1:0]  CD_LOAD = CD_W'(ATTACK_COOLDOWN);
    localparam logic [CD_W-1:0]  CD_ONE  = CD_W'(1);

    logic            step_tick_s;
    state_e          state_r;
    state_e          state_nxt_s;
    dir_e            dir_nxt_s;
    logic            fire_s;
    pick_t           pick_s;
    logic [CD_W-1:0] cooldown_r;
    logic [CD_W-1:0] cooldown_nxt_s;

    logic            move_req_s;
    logic [2:0]      move_dir_s;
    logic            attack_s;
    logic            busy_s;
    logic            move_req_r;
    logic [2:0]      move_dir_r;
    logic            attack_r;
    logic            busy_r;

    step_tick_gen #(
        .DIV (STEP_DIV)
    ) u_step_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (step_tick_s)
    );

    assign pick_s = pick_button(up, left, right, down, center);

    // State and cooldown registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cooldown_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            cooldown_r <= cooldown_nxt_s;
        end
    end

    // Next-state decode; ticks arriving outside IDLE are simply dropped, and a
    // blocked winning direction does not fall through to lower priorities.
    always_comb begin
        state_nxt_s = ST_IDLE;
        dir_nxt_s   = DIR_NONE;
        fire_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (step_tick_s && pick_s.is_dir && !blocked[pick_s.blk_idx]) begin
                    state_nxt_s = ST_REQ;
                    dir_nxt_s   = pick_s.dir;
                end else if (step_tick_s && pick_s.is_center && (cooldown_r == '0)) begin
                    state_nxt_s = ST_ATK;
                    fire_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (move_ack) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REQ;
                    dir_nxt_s   = dir_e'(move_dir_r);
                end
            end
            ST_ATK: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Cooldown: a fresh attack reload wins over the per-step decrement.
    always_comb begin
        cooldown_nxt_s = cooldown_r;
        if (fire_s) begin
            cooldown_nxt_s = CD_LOAD;
        end else if (step_tick_s && (cooldown_r != '0)) begin
            cooldown_nxt_s = cooldown_r - CD_ONE;
        end else begin
            cooldown_nxt_s = cooldown_r;
        end
    end

    // Output decode from the next state so the registered outputs track state_r.
    always_comb begin
        move_req_s = 1'b0;
        move_dir_s = DIR_NONE;
        attack_s   = 1'b0;
        busy_s     = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_REQ: begin
                move_req_s = 1'b1;
                move_dir_s = dir_nxt_s;
                busy_s     = 1'b1;
            end
            ST_ATK: begin
                attack_s = 1'b1;
                busy_s   = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            move_req_r <= 1'b0;
            move_dir_r <= DIR_NONE;
            attack_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            move_req_r <= move_req_s;
            move_dir_r <= move_dir_s;
            attack_r   <= attack_s;
            busy_r     <= busy_s;
        end
    end

    assign move_req = move_req_r;
    assign move_dir = move_dir_r;
    assign attack   = attack_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_hero_move_arbiter.sv
// Randomized and directed bench for hero_move_arbiter against a step-level
// behavioural model of the button/step/cooldown rules.
module tb_hero_move_arbiter;

    localparam int DIV = 4;
    localparam int CD  = 3;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       up       = 1'b0;
    logic       left     = 1'b0;
    logic       right    = 1'b0;
    logic       down     = 1'b0;
    logic       center   = 1'b0;
    logic [3:0] blocked  = 4'd0;
    logic       move_ack = 1'b0;
    logic       move_req;
    logic [2:0] move_dir;
    logic       attack;
    logic       busy;

    int total = 0;
    int bad   = 0;

    // Model: edges since reset release, outstanding command (0 = none),
    // attack-in-progress flag and remaining cooldown steps.
    int m_edges;
    int m_cmd;
    int m_cd;
    bit m_atk;

    always #5 clk = ~clk;

    hero_move_arbiter #(
        .STEP_DIV        (DIV),
        .ATTACK_COOLDOWN (CD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .up       (up),
        .left     (left),
        .right    (right),
        .down     (down),
        .center   (center),
        .blocked  (blocked),
        .move_ack (move_ack),
        .move_req (move_req),
        .move_dir (move_dir),
        .attack   (attack),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_edges = 0;
        m_cmd   = 0;
        m_cd    = 0;
        m_atk   = 1'b0;
    endtask

    task automatic model_edge();
        bit tick;
        bit fire;
        bit blk;
        int win;
        m_edges++;
        tick = ((m_edges % DIV) == 0);
        fire = 1'b0;
        if (m_cmd != 0) begin
            if (move_ack) m_cmd = 0;
        end else if (m_atk) begin
            m_atk = 1'b0;
        end else if (tick) begin
            win = up ? 1 : left ? 2 : right ? 3 : down ? 4 : center ? 5 : 0;
            case (win)
                1: blk = blocked[0];
                2: blk = blocked[1];
                3: blk = blocked[2];
                4: blk = blocked[3];
                default: blk = 1'b0;
            endcase
            if (win >= 1 && win <= 4) begin
                if (!blk) m_cmd = win;
            end else if (win == 5 && m_cd == 0) begin
                m_atk = 1'b1;
                fire  = 1'b1;
            end
        end
        if (fire) m_cd = CD;
        else if (tick && m_cd > 0) m_cd--;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("move_req", 32'(move_req), 32'(m_cmd != 0));
        chk("move_dir", 32'(move_dir), 32'(m_cmd));
        chk("attack",   32'(attack),   32'(m_atk));
        chk("busy",     32'(busy),     32'((m_cmd != 0) || m_atk));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_move_req", 32'(move_req), 32'd0);
        chk("rst_move_dir", 32'(move_dir), 32'd0);
        chk("rst_attack",   32'(attack),   32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic clear_inputs();
        up = 1'b0; left = 1'b0; right = 1'b0; down = 1'b0; center = 1'b0;
        blocked = 4'd0; move_ack = 1'b0;
    endtask

    initial begin
        int cnt;
        int first;
        model_reset();

        // Held UP with ack tied high: one-cycle request every step.
        apply_reset();
        up = 1'b1; move_ack = 1'b1;
        cnt = 0;
        repeat (16) begin step(); if (move_req) cnt++; end
        chk("up_req_cycles", 32'(cnt), 32'd4);

        // Blocked UP must not fall through to RIGHT.
        clear_inputs();
        apply_reset();
        up = 1'b1; right = 1'b1; blocked = 4'b0001; move_ack = 1'b1;
        cnt = 0;
        repeat (12) begin step(); if (move_req) cnt++; end
        chk("blocked_no_req", 32'(cnt), 32'd0);
        blocked = 4'b0000;
        cnt = 0;
        repeat (4) begin step(); if (move_req && move_dir == 3'd1) cnt++; end
        chk("unblocked_up", 32'(cnt), 32'd1);

        // LEFT with a late ack: command held, intervening ticks dropped.
        clear_inputs();
        apply_reset();
        left = 1'b1;
        cnt = 0;
        repeat (13) begin step(); if (move_req && move_dir == 3'd2) cnt++; end
        chk("left_hold_cycles", 32'(cnt), 32'd10);
        move_ack = 1'b1;
        step();
        chk("left_released", 32'(move_req), 32'd0);

        // Center held: fire, then three steps of cooldown.
        clear_inputs();
        apply_reset();
        center = 1'b1;
        cnt = 0; first = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (attack) begin
                cnt++;
                if (first == 0) first = i;
            end
        end
        chk("attack_count", 32'(cnt), 32'd3);
        chk("attack_first_edge", 32'(first), 32'd4);

        // Reset during REQ drops the command; next request after a full step.
        clear_inputs();
        apply_reset();
        down = 1'b1;
        repeat (5) step();
        chk("down_in_req", 32'(move_req), 32'd1);
        apply_reset();
        cnt = 0;
        while (!move_req && cnt < 20) begin step(); cnt++; end
        chk("post_rst_req_latency", 32'(cnt), 32'd4);

        // Random traffic with occasional resets.
        clear_inputs();
        apply_reset();
        repeat (1200) begin
            up       = ($urandom_range(0, 3) == 0);
            left     = ($urandom_range(0, 3) == 0);
            right    = ($urandom_range(0, 3) == 0);
            down     = ($urandom_range(0, 3) == 0);
            center   = ($urandom_range(0, 1) == 0);
            blocked  = 4'($urandom_range(0, 15));
            move_ack = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 199) == 0) apply_reset();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
